if_pc_gen: RTL and testbench

Fetch-stage PC generator and instruction-fetch sequencer. It owns the architectural fetch PC, issues one instruction-memory request at a time, and presents fetched instructions to decode. It consumes the execute-stage jump/branch resolution (taken flags plus targets) to redirect fetch and flush younger stages. Stale memory responses from the wrong path are discarded.

---
 rtl/if_pc_gen.sv | 141 ++++++++++++++
 tb/tb_if_pc_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: owns the fetch PC, runs one imem request at a time,
// presents fetched words to decode and redirects on execute-stage jumps/branches.
module if_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ex_valid,
  input  logic        i_ex_jump_taken,
  input  logic        i_ex_branch_taken,
  input  logic [63:0] i_ex_jump_target,
  input  logic [63:0] i_ex_branch_target,
  output logic        o_flush,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_if_valid,
  output logic [63:0] o_if_pc,
  output logic [31:0] o_if_instr,
  input  logic        i_id_stall,
  input  logic        i_id_compr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        redirect;
  logic [63:0] target;

  // Jump wins over branch; bit 0 is never a legal fetch address bit.
  assign redirect = i_ex_valid & (i_ex_jump_taken | i_ex_branch_taken);
  assign target   = i_ex_jump_taken ? {i_ex_jump_target[63:1], 1'b0}
                                    : {i_ex_branch_target[63:1], 1'b0};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (i_imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = i_imem_rsp_data;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!i_id_stall) begin
          pc_d       = pc_q + (i_id_compr ? 64'd2 : 64'd4);
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides everything above; an already-issued request becomes stale.
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      case (state_q)
        ST_REQ: begin
          if (i_imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (i_imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  assign req_valid_d = (state_d == ST_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 64'd0;
      if_instr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
    end
  end

  assign o_flush          = redirect & ~rst;
  assign o_imem_req_valid = req_valid_q;
  assign o_imem_addr      = pc_q;
  assign o_if_valid       = if_valid_q;
  assign o_if_pc          = if_pc_q;
  assign o_if_instr       = if_instr_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Randomized bench for if_pc_gen: memory model, architectural-PC reference model
// with an expected-fetch queue, and a monitor checking every presented instruction.
module tb_if_pc_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_v = 1'b0, ex_j = 1'b0, ex_b = 1'b0;
  logic [63:0] ex_jt = 64'd0, ex_bt = 64'd0;
  logic        o_flush, o_imem_req_valid, o_if_valid;
  logic [63:0] o_imem_addr, o_if_pc;
  logic [31:0] o_if_instr;
  logic        ready = 1'b0, rsp_v = 1'b0;
  logic [31:0] rsp_d = 32'd0;
  logic        stall = 1'b0, compr = 1'b0;

  if_pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .i_ex_valid(ex_v), .i_ex_jump_taken(ex_j), .i_ex_branch_taken(ex_b),
    .i_ex_jump_target(ex_jt), .i_ex_branch_target(ex_bt),
    .o_flush(o_flush),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(ready), .o_imem_addr(o_imem_addr),
    .i_imem_rsp_valid(rsp_v), .i_imem_rsp_data(rsp_d),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc), .o_if_instr(o_if_instr),
    .i_id_stall(stall), .i_id_compr(compr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int p_ready = 100, p_stall = 0, p_compr = 0, lat_min = 0, lat_max = 0;

  // memory model state
  bit          outstanding = 1'b0;
  logic [63:0] out_addr = 64'd0;
  int          lat = 0;
  bit          hs = 1'b0;
  logic [63:0] hs_addr = 64'd0;
  logic [63:0] req_log[$];

  // reference model: next PC decode should see, plus queue of expected presentations
  logic [63:0] model_pc = RST_PC;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] memw(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc = RST_PC;
    exp_q.push_back(model_pc);
  endtask

  task automatic step(input bit v, input bit j, input bit b,
                      input logic [63:0] jtv, input logic [63:0] btv);
    logic [63:0] t;
    @(posedge clk); #2;
    if (rsp_v) outstanding = 1'b0;
    if (hs) begin
      outstanding = 1'b1;
      out_addr    = hs_addr;
      lat         = $urandom_range(lat_min, lat_max);
    end
    rsp_v = 1'b0;
    rsp_d = $urandom;
    if (outstanding) begin
      if (lat == 0) begin
        rsp_v = 1'b1;
        rsp_d = memw(out_addr);
      end else begin
        lat--;
      end
    end
    ready = ($urandom_range(0, 99) < p_ready);
    if (o_imem_req_valid) chk("one_outstanding", 64'(outstanding), 64'd0);
    hs      = o_imem_req_valid && ready;
    hs_addr = o_imem_addr;
    if (hs) req_log.push_back(o_imem_addr);
    stall = ($urandom_range(0, 99) < p_stall);
    compr = ($urandom_range(0, 99) < p_compr);
    ex_v = v; ex_j = j; ex_b = b; ex_jt = jtv; ex_bt = btv;
    if (v && (j || b)) begin
      t = j ? jtv : btv;
      t[0] = 1'b0;
      model_pc = t;
      exp_q.delete();
      exp_q.push_back(model_pc);
    end else if (o_if_valid && !stall) begin
      model_pc = model_pc + (compr ? 64'd2 : 64'd4);
      exp_q.push_back(model_pc);
    end
  endtask

  task automatic step0();
    step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // monitor
  initial begin
    logic        prev_ifv = 1'b0, prev_req = 1'b0, prev_rst = 1'b1, redir;
    logic [63:0] prev_addr = 64'd0, prev_pc = 64'd0, tgt, e;
    logic [31:0] prev_instr = 32'd0;
    int          idle_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst && !prev_rst) begin
        idle_cnt++;
        if (o_if_valid && !prev_ifv) begin
          idle_cnt = 0;
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_fetch", o_if_pc, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("sb_if_pc", o_if_pc, e);
            chk("sb_if_instr", 64'(o_if_instr), 64'(memw(e)));
          end
        end
        if (idle_cnt > 400) begin
          chk("progress_timeout", 64'(idle_cnt), 64'd0);
          idle_cnt = 0;
        end
        redir = ex_v && (ex_j || ex_b);
        tgt = ex_j ? ex_jt : ex_bt;
        tgt[0] = 1'b0;
        if (redir) begin
          chk("redir_addr", o_imem_addr, tgt);
          chk("redir_ifv", 64'(o_if_valid), 64'd0);
        end else if (prev_ifv && stall) begin
          chk("stall_ifv", 64'(o_if_valid), 64'd1);
          chk("stall_pc", o_if_pc, prev_pc);
          chk("stall_instr", 64'(o_if_instr), 64'(prev_instr));
        end else if (prev_ifv) begin
          chk("accept_ifv", 64'(o_if_valid), 64'd0);
        end
        if (!redir && prev_req && !ready) begin
          chk("req_hold_valid", 64'(o_imem_req_valid), 64'd1);
          chk("req_hold_addr", o_imem_addr, prev_addr);
        end
      end
      prev_ifv = o_if_valid; prev_req = o_imem_req_valid; prev_addr = o_imem_addr;
      prev_pc = o_if_pc; prev_instr = o_if_instr; prev_rst = rst;
      @(negedge clk);
      chk("flush", 64'(o_flush), 64'(ex_v && (ex_j || ex_b) && !rst));
    end
  end

  initial begin
    logic [63:0] a, t1, t2;
    int r;
    model_reset();
    #12;
    chk("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
    chk("rst_addr", o_imem_addr, RST_PC);
    chk("rst_if_valid", 64'(o_if_valid), 64'd0);
    chk("rst_if_pc", o_if_pc, 64'd0);
    chk("rst_if_instr", 64'(o_if_instr), 64'd0);

    // zero-wait sequential fetch from RESET_PC
    @(posedge clk); #2;
    rst = 1'b0;
    step0(); chk("t1_ifv_c1", 64'(o_if_valid), 64'd0);
    step0(); chk("t1_ifv_c2", 64'(o_if_valid), 64'd0);
    step0(); chk("t1_ifv_c3", 64'(o_if_valid), 64'd1);
    for (int i = 0; i < 50 && req_log.size() < 3; i++) step0();
    chk("t1_nreq", 64'(req_log.size() >= 3), 64'd1);
    if (req_log.size() >= 3) begin
      chk("t1_req0", req_log[0], RST_PC);
      chk("t1_req1", req_log[1], RST_PC + 64'd4);
      chk("t1_req2", req_log[2], RST_PC + 64'd8);
    end

    // compressed stepping
    step(1'b1, 1'b1, 1'b0, 64'h100, 64'd0);
    req_log.delete();
    p_compr = 100;
    for (int i = 0; i < 50 && req_log.size() < 2; i++) step0();
    p_compr = 0;
    for (int i = 0; i < 50 && req_log.size() < 3; i++) step0();
    chk("t2_nreq", 64'(req_log.size() >= 3), 64'd1);
    if (req_log.size() >= 3) begin
      chk("t2_req0", req_log[0], 64'h100);
      chk("t2_req1", req_log[1], 64'h102);
      chk("t2_req2", req_log[2], 64'h106);
    end

    // jump while holding a stalled instruction
    p_stall = 100;
    for (int i = 0; i < 50 && !o_if_valid; i++) step0();
    chk("t3_hold", 64'(o_if_valid), 64'd1);
    step(1'b1, 1'b1, 1'b0, 64'h2001, 64'd0);
    @(negedge clk);
    chk("t3_flush", 64'(o_flush), 64'd1);
    p_stall = 0;
    step0();
    chk("t3_ifv", 64'(o_if_valid), 64'd0);
    chk("t3_addr", o_imem_addr, 64'h2000);
    chk("t3_req", 64'(o_imem_req_valid), 64'd1);

    // branch while waiting on a slow response
    lat_min = 2; lat_max = 2;
    step(1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
    for (int i = 0; i < 50 && !(hs && hs_addr == 64'h10); i++) step0();
    step0();
    step(1'b1, 1'b0, 1'b1, 64'd0, 64'h400);
    req_log.delete();
    for (int i = 0; i < 50 && !o_if_valid; i++) step0();
    chk("t4_pc", o_if_pc, 64'h400);
    chk("t4_instr", 64'(o_if_instr), 64'(memw(64'h400)));
    chk("t4_req0", (req_log.size() > 0) ? req_log[0] : 64'hX, 64'h400);

    // jump priority, then redirect coincident with a response
    lat_min = 0; lat_max = 0;
    step(1'b1, 1'b1, 1'b1, 64'h500, 64'h600);
    step0();
    chk("t5_addr", o_imem_addr, 64'h500);
    for (int i = 0; i < 50; i++) begin
      step0();
      if (hs) break;
    end
    step(1'b1, 1'b1, 1'b0, 64'h700, 64'd0);
    chk("t5_coincident_rsp", 64'(rsp_v), 64'd1);
    req_log.delete();
    step0();
    chk("t5_req_valid", 64'(o_imem_req_valid), 64'd1);
    chk("t5_addr2", o_imem_addr, 64'h700);
    for (int i = 0; i < 50 && !o_if_valid; i++) step0();
    chk("t5_pc", o_if_pc, 64'h700);
    chk("t5_nreq", 64'(req_log.size()), 64'd1);

    // ready held low: request must stay put
    p_ready = 0;
    for (int i = 0; i < 50 && !o_imem_req_valid; i++) step0();
    a = o_imem_addr;
    for (int i = 0; i < 5; i++) begin
      step0();
      chk("t6_req_valid", 64'(o_imem_req_valid), 64'd1);
      chk("t6_addr", o_imem_addr, a);
    end
    p_ready = 100;

    // async reset in WAIT, late response in IDLE
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 50; i++) begin
      step0();
      if (hs) break;
    end
    step0();
    #1 rst = 1'b1;
    #1;
    chk("t7_req_valid", 64'(o_imem_req_valid), 64'd0);
    chk("t7_addr", o_imem_addr, RST_PC);
    chk("t7_ifv", 64'(o_if_valid), 64'd0);
    chk("t7_if_pc", o_if_pc, 64'd0);
    chk("t7_if_instr", 64'(o_if_instr), 64'd0);
    lat = 100;
    model_reset();
    step0();
    step0();
    rst = 1'b0;
    rsp_v = 1'b1;
    rsp_d = memw(out_addr);
    outstanding = 1'b0;
    hs = 1'b0;
    req_log.delete();
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 50 && !o_if_valid; i++) step0();
    chk("t7_restart_pc", o_if_pc, RST_PC);
    chk("t7_restart_req", (req_log.size() > 0) ? req_log[0] : 64'hX, RST_PC);

    // randomized traffic
    p_ready = 70; p_stall = 30; p_compr = 30; lat_min = 0; lat_max = 3;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        case ($urandom_range(0, 3))
          0: t1 = {$urandom, $urandom};
          1: t1 = 64'hFFFF_FFFF_FFFF_FFFC;
          2: t1 = {32'd0, $urandom};
          default: t1 = {48'd0, 16'($urandom)};
        endcase
        t2 = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0: step(1'b1, 1'b1, 1'b0, t1, t2);
          1: step(1'b1, 1'b0, 1'b1, t2, t1);
          default: step(1'b1, 1'b1, 1'b1, t1, t2);
        endcase
      end else if (r < 11) begin
        step(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        step0();
      end
    end
    for (int i = 0; i < 10; i++) step0();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
